ex_mem_pipe_stage: RTL and testbench
====================================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
//  Sits between the ALU/EX stage and data memory; carries WB/MEM control bits, ALU result, store data and destination register.
//  Unlike a plain per-cycle latch, it absorbs MEM-side back-pressure without combinational ready paths, and can squash its contents.
// PARAMETERS
//  DATA_W      32  width of alu_result and write_data
//  REG_ADDR_W  5   width of write_reg
//  ZERO_GUARD  1   1: reg_write forced 0 at capture when write_reg==0
//  CNT_W       16  perf counter width (used only with EX_MEM_PERF_EN)
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           asynchronous, active-high reset
//  flush            in   1           synchronous squash of all held entries
//  in_valid         in   1           EX entry valid
//  in_ready         out  1           stage can accept (registered)
//  in_reg_write     in   1           WB control
//  in_mem_to_reg    in   1           WB control
//  in_mem_write     in   1           MEM control
//  in_mem_read      in   1           MEM control
//  in_alu_result    in   DATA_W      ALU result / address
//  in_write_data    in   DATA_W      store data
//  in_write_reg     in   REG_ADDR_W  destination register
//  out_valid        out  1           MEM entry valid
//  out_ready        in   1           MEM consumes entry
//  out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read  out 1 each   controls
//  out_alu_result, out_write_data  out DATA_W;  out_write_reg  out REG_ADDR_W
//  stall_cnt        out  CNT_W       [EX_MEM_PERF_EN only] back-pressure cycles
//  flush_cnt        out  CNT_W       [EX_MEM_PERF_EN only] effective flushes
// BEHAVIOUR
//  - Reset (async, rst=1): both entries invalid; out_valid=0, all out_* controls/data=0, in_ready=1, counters=0.
//  - Accept = in_valid & in_ready; issue = out_valid & out_ready. Outputs driven from main reg; skid reg is overflow.
//  - States: EMPTY (main invalid), ONE (main valid), FULL (main+skid valid). in_ready = (state!=FULL), from flop.
//    EMPTY: accept -> ONE (latency 1 cycle: out_valid next edge).
//    ONE: accept&issue -> ONE (main <= input); accept only -> FULL (skid <= input); issue only -> EMPTY.
//    FULL: issue -> ONE (main <= skid); no issue -> FULL, all held. No accept possible in FULL.
//  - Output controls gated: when out_valid=0, out_reg_write/mem_to_reg/mem_write/mem_read = 0 (bubble never writes).
//    Data outputs hold last value while invalid.
//  - ZERO_GUARD=1: entry captured with write_reg==0 stores reg_write=0; other fields unchanged.
//  - Outputs stable while out_valid & ~out_ready (no change until issue).
//  - flush=1 at edge: state -> EMPTY, same-cycle input dropped, same-cycle issue still counts to MEM but the entry is
//    removed; in_ready=1 next cycle. flush dominates accept. rst dominates all.
//  - Reset asserted mid-transfer: entries lost, no partial outputs; next cycle after deassert behaves as EMPTY.
// CONFIGURATION
//  EX_MEM_PERF_EN defined: stall_cnt +1 every cycle out_valid & ~out_ready; flush_cnt +1 each flush edge with
//    state!=EMPTY; both saturate at all-ones, cleared only by rst.
//  Undefined: stall_cnt/flush_cnt ports and logic absent; all other behaviour identical.
// TESTING
//  1 rst pulse mid-cycle -> out_valid=0, controls 0, in_ready=1 asynchronously, before next edge.
//  2 out_ready=1, push alu=0x10,wr_reg=5,reg_write=1 -> next cycle out_valid=1, out_alu_result=0x10, out_write_reg=5.
//  3 out_ready=0, push A=0x1,B=0x2 -> in_ready=0 after B; raise out_ready -> A then B issued in order, in_ready=1 again.
//  4 FULL then flush=1 with in_valid=1 (0x3) -> next cycle out_valid=0, out_mem_write=0, 0x3 never appears; flush_cnt=1.
//  5 push write_reg=0, reg_write=1 (ZERO_GUARD=1) -> out_reg_write=0, out_alu_result passes unchanged.
//  6 EX_MEM_PERF_EN, CNT_W=4, hold out_valid&~out_ready 20 cycles -> stall_cnt saturates at 0xF.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional perf counters (stall_cnt/flush_cnt) are present only when EX_MEM_PERF_EN is defined.
module ex_mem_pipe_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_GUARD = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_mem_write,
    input  logic                  in_mem_read,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_write_data,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_reg_write,
    output logic                  out_mem_to_reg,
    output logic                  out_mem_write,
    output logic                  out_mem_read,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_write_data,
    output logic [REG_ADDR_W-1:0] out_write_reg
`ifdef EX_MEM_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  mem_read;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     write_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nx;
    entry_t main_q, skid_q, in_entry;
    logic   accept, issue;
    logic   ld_main_in, ld_main_skid, ld_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    always_comb begin
        in_entry            = '0;
        in_entry.reg_write  = in_reg_write;
        in_entry.mem_to_reg = in_mem_to_reg;
        in_entry.mem_write  = in_mem_write;
        in_entry.mem_read   = in_mem_read;
        in_entry.alu_result = in_alu_result;
        in_entry.write_data = in_write_data;
        in_entry.write_reg  = in_write_reg;
        // Writes to the hard-wired zero register are neutralised at capture.
        if ((ZERO_GUARD != 0) && (in_write_reg == '0))
            in_entry.reg_write = 1'b0;
    end

    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    state_nx   = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: begin
                    if (accept && issue) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_nx = FULL;
                        ld_skid  = 1'b1;
                    end else if (issue) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: if (issue) begin
                    state_nx     = ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               main_q <= '0;
        else if (ld_main_in)   main_q <= in_entry;
        else if (ld_main_skid) main_q <= skid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          skid_q <= '0;
        else if (ld_skid) skid_q <= in_entry;
    end

    assign out_reg_write  = main_q.reg_write  & out_valid;
    assign out_mem_to_reg = main_q.mem_to_reg & out_valid;
    assign out_mem_write  = main_q.mem_write  & out_valid;
    assign out_mem_read   = main_q.mem_read   & out_valid;
    assign out_alu_result = main_q.alu_result;
    assign out_write_data = main_q.write_data;
    assign out_write_reg  = main_q.write_reg;

`ifdef EX_MEM_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt <= '0;
        else if (flush && (state != EMPTY) && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed self-checking bench for ex_mem_pipe_stage (perf counter checks need EX_MEM_PERF_EN).
module tb_ex_mem_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic        in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read;
    logic [31:0] in_alu_result, in_write_data;
    logic [4:0]  in_write_reg;
    logic        out_valid, out_ready;
    logic        out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read;
    logic [31:0] out_alu_result, out_write_data;
    logic [4:0]  out_write_reg;
`ifdef EX_MEM_PERF_EN
    logic [3:0]  stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(
        .DATA_W(32), .REG_ADDR_W(5), .ZERO_GUARD(1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_alu_result(in_alu_result), .in_write_data(in_write_data),
        .in_write_reg(in_write_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data),
        .out_write_reg(out_write_reg)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw, input logic mr,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = mr;
        in_mem_write  = mw;
        in_mem_read   = mr;
        in_alu_result = alu;
        in_write_data = wd;
        in_write_reg  = wr;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
        checks++; if ({out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read}); end
        checks++; if (out_alu_result !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 0", out_alu_result); end
`ifdef EX_MEM_PERF_EN
        checks++; if (stall_cnt !== 4'h0 || flush_cnt !== 4'h0) begin
            errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); end
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hAA, 5'd5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        checks++; if (out_alu_result !== 32'h10) begin errors++; $display("FAIL single_alu got %h exp 10", out_alu_result); end
        checks++; if (out_write_reg !== 5'd5) begin errors++; $display("FAIL single_wr got %0d exp 5", out_write_reg); end
        checks++; if (out_reg_write !== 1'b1) begin errors++; $display("FAIL single_rw got %0b exp 1", out_reg_write); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
            errors++; $display("FAIL single_drain got v=%0b rw=%0b exp 0/0", out_valid, out_reg_write); end
        checks++; if (out_alu_result !== 32'h10) begin errors++; $display("FAIL single_hold got %h exp 10", out_alu_result); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'hA1, 5'd1);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %0b exp 1", in_ready); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 32'hB2, 5'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b exp 0", in_ready); end
        tick();
        checks++; if (out_alu_result !== 32'h1 || out_mem_write !== 1'b1) begin
            errors++; $display("FAIL bp_hold got alu=%h mw=%0b exp 1/1", out_alu_result, out_mem_write); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h2) begin
            errors++; $display("FAIL bp_second got v=%0b alu=%h exp 1/2", out_valid, out_alu_result); end
        checks++; if (out_mem_write !== 1'b0 || out_write_data !== 32'hB2) begin
            errors++; $display("FAIL bp_second_fields got mw=%0b wd=%h exp 0/b2", out_mem_write, out_write_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_again got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hA, 32'h0, 5'd3);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hB, 32'h0, 5'd4);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %0b exp 0", in_ready); end
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 5'd6);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checks++; if (out_valid !== 1'b0 || out_mem_write !== 1'b0) begin
            errors++; $display("FAIL flush_out got v=%0b mw=%0b exp 0/0", out_valid, out_mem_write); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_alu_result !== 32'hA) begin
                errors++; $display("FAIL flush_no_ghost got v=%0b alu=%h exp 0/a", out_valid, out_alu_result); end
        end
`ifdef EX_MEM_PERF_EN
        checks++; if (flush_cnt !== 4'h1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", flush_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (flush_cnt !== 4'h1) begin errors++; $display("FAIL flush_cnt_empty got %0d exp 1", flush_cnt); end
`endif
    endtask

    task automatic test_zero_guard();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 32'h66, 5'd0);
        tick();
        checks++; if (out_reg_write !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL zg_rw got rw=%0b v=%0b exp 0/1", out_reg_write, out_valid); end
        checks++; if (out_alu_result !== 32'h55 || out_mem_read !== 1'b1) begin
            errors++; $display("FAIL zg_fields got alu=%h mr=%0b exp 55/1", out_alu_result, out_mem_read); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd7);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checks++; if (out_reg_write !== 1'b1 || out_write_reg !== 5'd7) begin
            errors++; $display("FAIL zg_nonzero got rw=%0b wr=%0d exp 1/7", out_reg_write, out_write_reg); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 32'h0, 5'(i + 1));
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_alu_result !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL b2b_%0d got v=%0b rdy=%0b alu=%h exp 1/1/%h", i, out_valid, in_ready,
                                   out_alu_result, 32'h100 + 32'(i)); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h21, 32'h0, 5'd9);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd10);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_state got v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
        checks++; if (out_reg_write !== 1'b0 || out_mem_write !== 1'b0 || out_alu_result !== 32'h0) begin
            errors++; $display("FAIL arst_out got rw=%0b mw=%0b alu=%h exp 0/0/0", out_reg_write, out_mem_write,
                               out_alu_result); end
`ifdef EX_MEM_PERF_EN
        checks++; if (flush_cnt !== 4'h0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", flush_cnt); end
`endif
        #2;
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %0b exp 0", out_valid); end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 5'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h30) begin
            errors++; $display("FAIL arst_push got v=%0b alu=%h exp 1/30", out_valid, out_alu_result); end
        tick();
    endtask

    task automatic test_stall_sat();
`ifdef EX_MEM_PERF_EN
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (20) tick();
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL stall_sat got %h exp f", stall_cnt); end
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h44) begin
            errors++; $display("FAIL stall_hold got v=%0b alu=%h exp 1/44", out_valid, out_alu_result); end
        out_ready = 1'b1;
        tick();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_zero_guard();
        test_back_to_back();
        test_async_reset();
        test_stall_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
